// File: rtl/com_uart_responder.sv
// Memory-mapped 8N1 UART responder on the com bus: TX/RX FIFOs, baud timing, sticky errors, interrupt.
// Optional internal loopback (CTRL[3]) is compiled in when COM_UART_LOOPBACK_EN is defined.
module com_uart_responder #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         CLK_DIV    = 434,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] com_addr,
  input  logic [7:0] com_wr,
  output logic [7:0] com_rd,
  output logic       com_interrupt,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Bus strobe: a side effect fires once, on the first cycle com_addr lands on one of our
  // four registers with a value different from last cycle; com_rd is valid whenever addressed.
  logic [7:0] prev_addr;
  logic       hit, strobe;
  logic       acc_tx, acc_rx, acc_stat, acc_ctrl;

  assign hit      = (com_addr[7:2] == BASE_ADDR[7:2]);
  assign strobe   = hit && (com_addr != prev_addr);
  assign acc_tx   = strobe && (com_addr[1:0] == 2'd0);
  assign acc_rx   = strobe && (com_addr[1:0] == 2'd1);
  assign acc_stat = strobe && (com_addr[1:0] == 2'd2);
  assign acc_ctrl = strobe && (com_addr[1:0] == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) prev_addr <= 8'h00;
    else      prev_addr <= com_addr;
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_cnt == FIFO_FULL);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = acc_tx && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= com_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  // TX FSM
  uart_state_t tx_state, tx_next;
  logic [CW-1:0] tx_baud;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick, tx_line, tx_busy;

  assign tx_tick = (tx_baud == BIT_LAST);
  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= S_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty) tx_next = S_START;
      S_START: if (tx_tick) tx_next = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_tick) tx_next = tx_empty ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE:  tx_pop = !tx_empty;
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift[0];
      S_STOP:  tx_pop = tx_tick && !tx_empty;
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_baud  <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
    end else if (tx_pop) begin
      tx_shift <= tx_mem[tx_rp];
      tx_baud  <= '0;
      tx_bit   <= 3'd0;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_baud <= '0;
        if (tx_state == S_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_baud <= tx_baud + CW'(1);
      end
    end
  end

  // CTRL register and serial routing
  logic       rx_in;
  logic [7:0] ctrl_rd;
`ifdef COM_UART_LOOPBACK_EN
  logic [3:0] ctrl_q;
  always_ff @(posedge clk) begin
    if (!rst)                       ctrl_q <= 4'h0;
    else if (acc_ctrl && com_wr[7]) ctrl_q <= com_wr[3:0];
  end
  assign ctrl_rd = {4'h0, ctrl_q};
  assign uart_tx = ctrl_q[3] ? 1'b1 : tx_line;
  assign rx_in   = ctrl_q[3] ? tx_line : uart_rx;
`else
  logic [2:0] ctrl_q;
  always_ff @(posedge clk) begin
    if (!rst)                       ctrl_q <= 3'h0;
    else if (acc_ctrl && com_wr[7]) ctrl_q <= com_wr[2:0];
  end
  assign ctrl_rd = {5'h00, ctrl_q};
  assign uart_tx = tx_line;
  assign rx_in   = uart_rx;
`endif

  // RX synchroniser; rx_prev gives the falling-edge reference in the synchronised domain
  logic rx_s1, rx_s2, rx_prev, rx_fall;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end
  assign rx_fall = rx_prev && !rx_s2;

  // RX FSM
  uart_state_t rx_state, rx_next;
  logic [CW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_half, rx_done_ok, frm_set;

  assign rx_tick = (rx_baud == BIT_LAST);
  assign rx_half = (rx_baud == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= S_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done_ok = 1'b0;
    frm_set    = 1'b0;
    if (rx_state == S_STOP && rx_tick) begin
      rx_done_ok = rx_s2;
      frm_set    = !rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_baud  <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_baud <= '0;
          rx_bit  <= 3'd0;
        end
        S_START: rx_baud <= rx_half ? '0 : rx_baud + CW'(1);
        S_DATA: begin
          if (rx_tick) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_baud <= rx_baud + CW'(1);
          end
        end
        default: rx_baud <= rx_tick ? '0 : rx_baud + CW'(1);
      endcase
    end
  end

  // RX FIFO; a full FIFO drops the incoming byte even if a pop happens the same cycle
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovf_set;

  assign rx_full    = (rx_cnt == FIFO_FULL);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_push    = rx_done_ok && !rx_full;
  assign rx_ovf_set = rx_done_ok && rx_full;
  assign rx_pop     = acc_rx && !rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  // Sticky flags: a new event wins over a simultaneous W1C clear
  logic frm_err, rx_ovf, tx_ovf;
  always_ff @(posedge clk) begin
    if (!rst) begin
      frm_err <= 1'b0;
      rx_ovf  <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      if (acc_stat) begin
        frm_err <= frm_err & ~com_wr[6];
        rx_ovf  <= rx_ovf  & ~com_wr[5];
        tx_ovf  <= tx_ovf  & ~com_wr[4];
      end
      if (frm_set)            frm_err <= 1'b1;
      if (rx_ovf_set)         rx_ovf  <= 1'b1;
      if (acc_tx && tx_full)  tx_ovf  <= 1'b1;
    end
  end

  logic irq_cond;
  assign irq_cond = (ctrl_q[0] && !rx_empty)
                  | (ctrl_q[1] && tx_empty && !tx_busy)
                  | (ctrl_q[2] && (frm_err || rx_ovf || tx_ovf));

  always_ff @(posedge clk) begin
    if (!rst) com_interrupt <= 1'b0;
    else      com_interrupt <= irq_cond;
  end

  logic [7:0] status;
  assign status = {com_interrupt, frm_err, rx_ovf, tx_ovf, tx_busy, tx_full, !rx_empty, tx_empty};

  always_comb begin
    com_rd = 8'h00;
    if (rst && hit) begin
      case (com_addr[1:0])
        2'd0:    com_rd = status;
        2'd1:    com_rd = rx_empty ? 8'h00 : rx_mem[rx_rp];
        2'd2:    com_rd = status;
        default: com_rd = ctrl_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_com_uart_responder.sv
// Self-checking bench for com_uart_responder (CLK_DIV=4, FIFO_DEPTH=4, BASE_ADDR='h10).
module tb_com_uart_responder;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] A_TX = 8'h10, A_RX = 8'h11, A_ST = 8'h12, A_CT = 8'h13;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] com_addr = 8'h00;
  logic [7:0] com_wr = 8'h00;
  logic [7:0] com_rd;
  logic       com_interrupt;
  logic       uart_tx;
  logic       uart_rx = 1'b1;

  int total = 0;
  int bad = 0;
  int tx_stop_errs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rx_exp_q[$];

  com_uart_responder #(.BASE_ADDR(8'h10), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .com_addr(com_addr), .com_wr(com_wr), .com_rd(com_rd),
    .com_interrupt(com_interrupt), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // serial line decoder: samples each bit near its middle
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge uart_tx);
      repeat (DIV / 2) @(negedge clk);
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        d[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      if (uart_tx !== 1'b1) tx_stop_errs++;
      got_q.push_back(d);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_read(input logic [7:0] a, input logic [7:0] wd, output logic [7:0] d);
    @(negedge clk);
    com_addr = a;
    com_wr   = wd;
    #1 d = com_rd;
    @(negedge clk);
    com_addr = 8'h00;
    com_wr   = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] wd);
    logic [7:0] unused_d;
    bus_read(a, wd, unused_d);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input string name);
    logic [7:0] st;
    int n;
    n = 0;
    do begin
      bus_read(A_ST, 8'h00, st);
      n++;
    end while (((st & 8'h09) != 8'h01) && n < 400);
    check(name, (n < 400), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tx_sb(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    check({name, "_stop"}, tx_stop_errs, 0);
    got_q.delete();
    exp_q.delete();
    tx_stop_errs = 0;
  endtask

  typedef struct {
    logic [7:0] wdata;
    logic [7:0] ctrl;
    logic       irq;
  } ctrl_vec_t;

  initial begin
    ctrl_vec_t  tv[7];
    logic [7:0] d, st, b, all_ctrl;
    logic [39:0] cap, exp_s;
    int k, n;
    logic stop_ok, exp_frm, exp_ovf, low_seen;

`ifdef COM_UART_LOOPBACK_EN
    all_ctrl = 8'h0F;
`else
    all_ctrl = 8'h07;
`endif
    tv[0] = '{8'h81, 8'h01, 1'b0};
    tv[1] = '{8'h06, 8'h01, 1'b0};
    tv[2] = '{8'h82, 8'h02, 1'b1};
    tv[3] = '{8'hFF, all_ctrl, 1'b1};
    tv[4] = '{8'h7F, all_ctrl, 1'b1};
    tv[5] = '{8'hF4, 8'h04, 1'b0};
    tv[6] = '{8'h80, 8'h00, 1'b0};

    // reset
    repeat (3) @(negedge clk);
    com_addr = A_ST;
    #1 check("rd_in_reset", com_rd, 8'h00);
    com_addr = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_irq", com_interrupt, 1'b0);
    bus_read(A_ST, 8'h00, st);
    check("reset_status", st, 8'h01);
    bus_read(A_CT, 8'h00, d);
    check("reset_ctrl", d, 8'h00);
    bus_read(A_RX, 8'h00, d);
    check("reset_rx_empty", d, 8'h00);
    bus_read(8'h20, 8'h00, d);
    check("unaddressed_20", d, 8'h00);
    bus_read(8'h0F, 8'h00, d);
    check("unaddressed_0f", d, 8'h00);

    // CTRL table
    foreach (tv[i]) begin
      bus_write(A_CT, tv[i].wdata);
      @(negedge clk);
      check($sformatf("ctrl_irq_%0d", i), com_interrupt, tv[i].irq);
      bus_read(A_CT, 8'h00, d);
      check($sformatf("ctrl_rd_%0d", i), d, tv[i].ctrl);
      bus_read(A_ST, 8'h00, st);
      check($sformatf("ctrl_st7_%0d", i), st[7], tv[i].irq);
    end

    // single byte, exact waveform
    b = 8'hA5;
    for (int i = 0; i < 40; i++)
      exp_s[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
    exp_q.push_back(b);
    bus_read(A_TX, b, d);
    check("txdata_reads_status", d, 8'h01);
    k = 0;
    while (uart_tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tx_start_seen", (k < 10), 1'b1);
    for (int i = 0; i < 40; i++) begin
      cap[i] = uart_tx;
      @(negedge clk);
    end
    check("tx_wave_a5", cap, exp_s);
    bus_read(A_ST, 8'h00, st);
    check("status_after_stop", st, 8'h01);
    wait_tx_idle("a5_idle");
    check_tx_sb("a5");

    // held address fires once
    @(negedge clk);
    com_addr = A_TX;
    com_wr   = 8'h3C;
    repeat (3) @(negedge clk);
    com_addr = 8'h00;
    com_wr   = 8'h00;
    exp_q.push_back(8'h3C);
    wait_tx_idle("hold_idle");
    check_tx_sb("hold");

    // overflow: one popped at once, DEPTH queued, the rest dropped
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, b);
      if (i < DEPTH + 1) exp_q.push_back(b);
    end
    bus_read(A_ST, 8'h00, st);
    check("ovf_status", st, 8'h1C);
    bus_write(A_ST, 8'h10);
    bus_read(A_ST, 8'h00, st);
    check("ovf_cleared", st, 8'h0C);
    wait_tx_idle("ovf_idle");
    check_tx_sb("ovf");

    // random TX bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(A_TX, b);
      end
      wait_tx_idle("rand_idle");
      check_tx_sb("rand_tx");
    end

    // RX single frame
    send_frame(8'h5A, 1'b1);
    bus_read(A_ST, 8'h00, st);
    check("rx_status_full", st, 8'h03);
    bus_read(A_RX, 8'h00, d);
    check("rx_byte_5a", d, 8'h5A);
    bus_read(A_RX, 8'h00, d);
    check("rx_second_read", d, 8'h00);
    bus_read(A_ST, 8'h00, st);
    check("rx_status_empty", st, 8'h01);

    // framing error and err interrupt
    send_frame(8'h33, 1'b0);
    bus_read(A_ST, 8'h00, st);
    check("frm_status", st, 8'h41);
    bus_write(A_CT, 8'h84);
    check("frm_irq_not_early", com_interrupt, 1'b0);
    @(negedge clk);
    check("frm_irq", com_interrupt, 1'b1);
    bus_write(A_ST, 8'h40);
    bus_write(A_CT, 8'h80);
    @(negedge clk);
    check("frm_irq_cleared", com_interrupt, 1'b0);

    // RX rounds: round 0 forces an overflow, later rounds are random
    for (int r = 0; r < 3; r++) begin
      bus_write(A_ST, 8'h70);
      bus_read(A_ST, 8'h00, st);
      check("rx_flags_clear", st & 8'h70, 8'h00);
      exp_frm = 1'b0;
      exp_ovf = 1'b0;
      n = (r == 0) ? DEPTH + 1 : $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        stop_ok = (r == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        send_frame(b, stop_ok);
        if (!stop_ok) exp_frm = 1'b1;
        else if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
        else exp_ovf = 1'b1;
      end
      bus_read(A_ST, 8'h00, st);
      check("rx_frm_flag", st[6], exp_frm);
      check("rx_ovf_flag", st[5], exp_ovf);
      check("rx_nonempty", st[1], (rx_exp_q.size() > 0));
      while (rx_exp_q.size() > 0) begin
        bus_read(A_RX, 8'h00, d);
        check("rx_byte", d, rx_exp_q.pop_front());
      end
      bus_read(A_RX, 8'h00, d);
      check("rx_drained", d, 8'h00);
    end
    bus_write(A_ST, 8'h70);

`ifdef COM_UART_LOOPBACK_EN
    bus_write(A_CT, 8'h88);
    bus_read(A_CT, 8'h00, d);
    check("lb_ctrl", d, 8'h08);
    bus_write(A_TX, 8'h77);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (uart_tx !== 1'b1) low_seen = 1'b1;
      @(negedge clk);
    end
    check("lb_tx_held", low_seen, 1'b0);
    bus_read(A_RX, 8'h00, d);
    check("lb_rx_byte", d, 8'h77);
    wait_tx_idle("lb_idle");
    check_tx_sb("lb");
    bus_write(A_CT, 8'h80);
`else
    bus_write(A_CT, 8'h88);
    bus_read(A_CT, 8'h00, d);
    check("no_lb_ctrl", d, 8'h00);
`endif

    // reset mid-frame on both directions
    uart_rx = 1'b0;
    repeat (DIV * 3) @(negedge clk);
    bus_write(A_TX, 8'hC3);
    k = 0;
    while (uart_tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rst_tx_started", (k < 10), 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_high", uart_tx, 1'b1);
    com_addr = A_ST;
    #1 check("rst_rd_zero", com_rd, 8'h00);
    com_addr = 8'h00;
    uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus_read(A_ST, 8'h00, st);
    check("rst_status", st, 8'h01);
    repeat (DIV * 12) @(negedge clk);
    bus_read(A_ST, 8'h00, st);
    check("rst_no_phantom", st, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
